// File: rtl/simd_alu_issue_seq.sv
// rtl/simd_alu_issue_seq.sv - serialises a SIMD vector instruction onto one shared scalar ALU
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     instruction handshake; in_op, in_a, in_b latched on accept
//   alu_a/alu_b/alu_select  operands and opcode driven to the combinational ALU
//   alu_result/alu_nop    ALU response for the lane currently being issued
//   out_valid/out_ready   result handshake; out_result holds LANES lanes of N bits
//   out_nop/out_illegal/out_divz  status for the returned instruction
//   busy                  high whenever the sequencer is not idle
module simd_alu_issue_seq #(
  parameter int N     = 32,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [3:0]         alu_select,
  input  logic [N-1:0]       alu_result,
  input  logic               alu_nop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_result,
  output logic               out_nop,
  output logic               out_illegal,
  output logic [LANES-1:0]   out_divz,
  output logic               busy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MAX = 4'b1000;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t               state, state_nx;
  logic [3:0]           op_q;
  logic [LANES*N-1:0]   a_q, b_q, res_q;
  logic [LW-1:0]        lane_q;
  logic                 nop_q, ill_q;
  logic [LANES-1:0]     divz_q;
  logic [N-1:0]         a_lane, b_lane;
  logic                 accept, illegal_op;

  assign illegal_op = (in_op > OP_MAX);
  assign accept     = (state == IDLE) && in_valid;

  // Lane select from the latched operand vectors.
  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LW'(i)) begin
        a_lane = a_q[i*N +: N];
        b_lane = b_q[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    alu_a      = '0;
    alu_b      = '0;
    alu_select = OP_NOP;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          // NOP and illegal opcodes never touch the ALU.
          if (in_op == OP_NOP || illegal_op) state_nx = DONE;
          else                               state_nx = ISSUE;
        end
      end
      ISSUE: begin
        alu_a      = a_lane;
        alu_b      = b_lane;
        alu_select = op_q;
        if (lane_q == LAST_LANE) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      lane_q <= '0;
      nop_q  <= 1'b0;
      ill_q  <= 1'b0;
      divz_q <= '0;
    end else if (accept) begin
      op_q   <= in_op;
      a_q    <= in_a;
      b_q    <= in_b;
      res_q  <= '0;
      lane_q <= '0;
      nop_q  <= (in_op == OP_NOP);
      ill_q  <= illegal_op;
      divz_q <= '0;
    end else if (state == ISSUE) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_q == LW'(i)) begin
          // Divide by zero saturates the lane regardless of what the ALU returns.
          if (op_q == OP_DIV && b_lane == '0) begin
            res_q[i*N +: N] <= '1;
            divz_q[i]       <= 1'b1;
          end else begin
            res_q[i*N +: N] <= alu_result;
          end
        end
      end
      // An ALU that reports nop on a real opcode marks the whole instruction bad.
      if (alu_nop) ill_q <= 1'b1;
      lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
    end
  end

  assign out_result  = res_q;
  assign out_nop     = nop_q;
  assign out_illegal = ill_q;
  assign out_divz    = divz_q;

endmodule

// File: tb/tb_simd_alu_issue_seq.sv
// tb/tb_simd_alu_issue_seq.sv - scoreboard bench for simd_alu_issue_seq with a behavioural ALU
module tb_simd_alu_issue_seq;
  localparam int N = 32;
  localparam int L = 4;
  localparam int W = L * N;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [3:0]     in_op = 4'h0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic [N-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]     alu_select;
  logic           alu_nop;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_result;
  logic           out_nop, out_illegal, busy;
  logic [L-1:0]   out_divz;

  typedef struct {
    logic [W-1:0] res;
    logic         nop;
    logic         ill;
    logic [L-1:0] divz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic         prev_v = 1'b0;
  logic [W-1:0] held = '0;

  simd_alu_issue_seq #(.N(N), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_result(alu_result), .alu_nop(alu_nop),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nop(out_nop), .out_illegal(out_illegal), .out_divz(out_divz), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scalar ALU; operand a = DEADBEEF makes it flag nop to exercise the sticky illegal path.
  always_comb begin
    case (alu_select)
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a * alu_b;
      4'd3:    alu_result = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
      4'd4:    alu_result = alu_a & alu_b;
      4'd5:    alu_result = alu_a | alu_b;
      4'd6:    alu_result = (alu_b >= 32) ? 32'd0 : alu_a >> alu_b;
      4'd7:    alu_result = (alu_b >= 32) ? 32'd0 : alu_a << alu_b;
      4'd8:    alu_result = alu_a + alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_nop = (alu_select == 4'd0) || (alu_a == 32'hDEADBEEF);
  end

  function automatic logic [W-1:0] pk(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: pops on the first cycle of each result, then checks that it holds.
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        timeout("unexpected_out_valid");
      end else begin
        mon_e = sb.pop_front();
        chk("result", out_result, mon_e.res);
        chk("flags", W'({out_nop, out_illegal, out_divz}), W'({mon_e.nop, mon_e.ill, mon_e.divz}));
        chk("latency", W'(cyc - mon_e.acc + 1), W'(mon_e.lat));
        held = out_result;
      end
    end else if (out_valid && prev_v) begin
      chk("hold_result", out_result, held);
      chk("hold_in_ready", W'(in_ready), W'(0));
    end
    prev_v = out_valid;
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic nop, input logic ill,
                       input logic [L-1:0] dz, input int lat, input int hold);
    exp_t e;
    int   k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    if (!in_ready) begin timeout("wait_in_ready"); return; end
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    e.res = res; e.nop = nop; e.ill = ill; e.divz = dz; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    in_op = 4'($urandom);
    in_a = {$urandom, $urandom, $urandom, $urandom};
    in_b = {$urandom, $urandom, $urandom, $urandom};
    if (op == 4'd0) chk("nop_alu_select", W'(alu_select), W'(0));
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    if (!out_valid) begin timeout("wait_out_valid"); return; end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff", W'({in_ready, out_valid, busy}), W'(3'b100));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_state", W'({in_ready, busy, out_valid, out_nop, out_illegal, out_divz, alu_select, alu_a, alu_b}),
        W'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 32'b0, 32'b0}));
    chk("reset_result", out_result, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(4'd8, pk(1, 2, 3, 32'hFFFFFFFF), pk(10, 20, 30, 1), pk(11, 22, 33, 0), 0, 0, 4'b0000, 5, 0);
    issue(4'd1, pk(3, 10, 0, 100), pk(5, 4, 1, 100), pk(32'hFFFFFFFE, 6, 32'hFFFFFFFF, 0), 0, 0, 4'b0000, 5, 0);
    issue(4'd2, pk(2, 32'h10000, 32'hFFFFFFFF, 7), pk(3, 32'h10000, 2, 0), pk(6, 0, 32'hFFFFFFFE, 0), 0, 0, 4'b0000, 5, 0);
    issue(4'd3, pk(100, 7, 9, 0), pk(10, 0, 3, 0), pk(10, 32'hFFFFFFFF, 3, 32'hFFFFFFFF), 0, 0, 4'b1010, 5, 3);
    issue(4'd0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0, 1, 0, 4'b0000, 1, 0);
    issue(4'd15, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0, 0, 1, 4'b0000, 1, 0);
    issue(4'd9, pk(1, 2, 3, 4), pk(5, 6, 7, 8), '0, 0, 1, 4'b0000, 1, 0);
    issue(4'd4, pk(32'hFF00, 32'hDEADBEEF, 0, 32'hFFFFFFFF), pk(32'h0FF0, 32'hFFFF0000, 32'h1234, 32'h12345678),
          pk(32'h0F00, 32'hDEAD0000, 0, 32'h12345678), 0, 1, 4'b0000, 5, 0);
    issue(4'd6, pk(32'h80000000, 32'hF0, 32'hFFFFFFFF, 5), pk(31, 4, 32, 0), pk(1, 32'hF, 0, 5), 0, 0, 4'b0000, 5, 0);
    issue(4'd7, pk(1, 3, 32'hFFFFFFFF, 1), pk(31, 4, 33, 1), pk(32'h80000000, 32'h30, 0, 2), 0, 0, 4'b0000, 5, 0);
    issue(4'd5, pk(32'hF0, 0, 32'hA5A5A5A5, 1), pk(32'h0F, 0, 32'h5A5A5A5A, 2), pk(32'hFF, 0, 32'hFFFFFFFF, 3), 0, 0, 4'b0000, 5, 1);

    // Abort an ADD while lane 2 is on the ALU.
    @(negedge clk);
    in_op = 4'd8; in_a = pk(1, 2, 3, 4); in_b = pk(5, 6, 7, 8); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("lane2_alu_a", W'(alu_a), W'(3));
    rst_n = 1'b0;
    #1;
    chk("async_reset", W'({in_ready, busy, out_valid, out_nop, out_illegal, out_divz, alu_select, alu_a, alu_b}),
        W'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 32'b0, 32'b0}));
    chk("async_reset_result", out_result, '0);
    repeat (2) @(negedge clk);
    chk("reset_no_valid", W'(out_valid), W'(0));
    rst_n = 1'b1;

    issue(4'd8, pk(5, 6, 7, 8), pk(1, 1, 1, 1), pk(6, 7, 8, 9), 0, 0, 4'b0000, 5, 0);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
